id_ex_stage: RTL and testbench

Pipeline register between ID and EX of the 5-stage RISC-V core, with integrated load-use hazard detection. It captures the decoded controls, operands and register addresses each cycle. It inserts a one-cycle bubble when the instruction in EX is a load whose rd is read by the instruction in ID. It supplies the EX-stage rs1/rs2/rd addresses consumed by the forwarding unit, and keeps saturating stall and flush event counters for performance analysis.

---
 rtl/id_ex_if.sv | 67 ++++++
 rtl/id_ex_stage.sv | 109 ++++++++++
 tb/tb_id_ex_stage.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// ID/EX bundle: the decoded ID instruction going into the stage, and the
// registered EX view, hazard stall and event counters coming back out.
//
// Stall protocol: this path has no valid/ready pair. Stall_o is a
// combinational hold request for the same cycle. While it is high, the
// master must keep PC and IF/ID frozen, so the ID inputs are presented again
// on the next cycle. The stage always accepts whatever is presented when it
// is not stalling. Flush_i squashes the ID instruction at the next edge.
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic              IDRegWrite_i;
  logic              IDMemtoReg_i;
  logic              IDMemRead_i;
  logic              IDMemWrite_i;
  logic              IDALUSrc_i;
  logic [1:0]        IDALUOp_i;
  logic [9:0]        IDfunct_i;
  logic [DATA_W-1:0] IDRS1data_i;
  logic [DATA_W-1:0] IDRS2data_i;
  logic [DATA_W-1:0] IDImm_i;
  logic [4:0]        IDRS1addr_i;
  logic [4:0]        IDRS2addr_i;
  logic [4:0]        IDRDaddr_i;
  logic              Flush_i;

  logic              EXRegWrite_o;
  logic              EXMemtoReg_o;
  logic              EXMemRead_o;
  logic              EXMemWrite_o;
  logic              EXALUSrc_o;
  logic [1:0]        EXALUOp_o;
  logic [9:0]        EXfunct_o;
  logic [DATA_W-1:0] EXRS1data_o;
  logic [DATA_W-1:0] EXRS2data_o;
  logic [DATA_W-1:0] EXImm_o;
  logic [4:0]        EXRS1addr_o;
  logic [4:0]        EXRS2addr_o;
  logic [4:0]        EXRDaddr_o;
  logic              EXValid_o;
  logic              Stall_o;
  logic [CNT_W-1:0]  StallCount_o;
  logic [CNT_W-1:0]  FlushCount_o;

  // Decode side: drives the ID instruction and consumes the EX view.
  modport master (
    output IDRegWrite_i, IDMemtoReg_i, IDMemRead_i, IDMemWrite_i, IDALUSrc_i,
           IDALUOp_i, IDfunct_i, IDRS1data_i, IDRS2data_i, IDImm_i,
           IDRS1addr_i, IDRS2addr_i, IDRDaddr_i, Flush_i,
    input  EXRegWrite_o, EXMemtoReg_o, EXMemRead_o, EXMemWrite_o, EXALUSrc_o,
           EXALUOp_o, EXfunct_o, EXRS1data_o, EXRS2data_o, EXImm_o,
           EXRS1addr_o, EXRS2addr_o, EXRDaddr_o, EXValid_o, Stall_o,
           StallCount_o, FlushCount_o
  );

  // Pipeline stage side.
  modport slave (
    input  IDRegWrite_i, IDMemtoReg_i, IDMemRead_i, IDMemWrite_i, IDALUSrc_i,
           IDALUOp_i, IDfunct_i, IDRS1data_i, IDRS2data_i, IDImm_i,
           IDRS1addr_i, IDRS2addr_i, IDRDaddr_i, Flush_i,
    output EXRegWrite_o, EXMemtoReg_o, EXMemRead_o, EXMemWrite_o, EXALUSrc_o,
           EXALUOp_o, EXfunct_o, EXRS1data_o, EXRS2data_o, EXImm_o,
           EXRS1addr_o, EXRS2addr_o, EXRDaddr_o, EXValid_o, Stall_o,
           StallCount_o, FlushCount_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and saturating stall/flush event counters.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic   clk_i,
  input  logic   rst_i,
  id_ex_if.slave bus
);

  logic              r_reg_write;
  logic              r_mem_to_reg;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_alu_src;
  logic [1:0]        r_alu_op;
  logic [9:0]        r_funct;
  logic [DATA_W-1:0] r_rs1_data;
  logic [DATA_W-1:0] r_rs2_data;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_rs1_addr;
  logic [4:0]        r_rs2_addr;
  logic [4:0]        r_rd_addr;
  logic              r_valid;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_stall;
  logic              w_bubble;
  logic              w_stall_event;

  // Load-use hazard: a real load in EX writing a nonzero rd that ID reads.
  // Because a bubble clears r_mem_read, this cannot hold two cycles running.
  assign w_stall = r_mem_read && r_valid && (r_rd_addr != 5'd0) &&
                   ((r_rd_addr == bus.IDRS1addr_i) ||
                    (r_rd_addr == bus.IDRS2addr_i));

  // Flush wins over stall; both load a bubble.
  assign w_bubble      = bus.Flush_i || w_stall;
  assign w_stall_event = w_stall && !bus.Flush_i;

  // Pipeline register: reset or bubble zeroes everything, else capture ID.
  always_ff @(posedge clk_i) begin
    if (!rst_i || w_bubble) begin
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_op     <= 2'd0;
      r_funct      <= 10'd0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_rs1_addr   <= 5'd0;
      r_rs2_addr   <= 5'd0;
      r_rd_addr    <= 5'd0;
      r_valid      <= 1'b0;
    end else begin
      r_reg_write  <= bus.IDRegWrite_i;
      r_mem_to_reg <= bus.IDMemtoReg_i;
      r_mem_read   <= bus.IDMemRead_i;
      r_mem_write  <= bus.IDMemWrite_i;
      r_alu_src    <= bus.IDALUSrc_i;
      r_alu_op     <= bus.IDALUOp_i;
      r_funct      <= bus.IDfunct_i;
      r_rs1_data   <= bus.IDRS1data_i;
      r_rs2_data   <= bus.IDRS2data_i;
      r_imm        <= bus.IDImm_i;
      r_rs1_addr   <= bus.IDRS1addr_i;
      r_rs2_addr   <= bus.IDRS2addr_i;
      r_rd_addr    <= bus.IDRDaddr_i;
      r_valid      <= 1'b1;
    end
  end

  // Event counters, saturating at all-ones; a flush+stall edge counts as a flush.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (bus.Flush_i && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (w_stall_event && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.EXRegWrite_o = r_reg_write;
  assign bus.EXMemtoReg_o = r_mem_to_reg;
  assign bus.EXMemRead_o  = r_mem_read;
  assign bus.EXMemWrite_o = r_mem_write;
  assign bus.EXALUSrc_o   = r_alu_src;
  assign bus.EXALUOp_o    = r_alu_op;
  assign bus.EXfunct_o    = r_funct;
  assign bus.EXRS1data_o  = r_rs1_data;
  assign bus.EXRS2data_o  = r_rs2_data;
  assign bus.EXImm_o      = r_imm;
  assign bus.EXRS1addr_o  = r_rs1_addr;
  assign bus.EXRS2addr_o  = r_rs2_addr;
  assign bus.EXRDaddr_o   = r_rd_addr;
  assign bus.EXValid_o    = r_valid;
  assign bus.Stall_o      = w_stall;
  assign bus.StallCount_o = r_stall_cnt;
  assign bus.FlushCount_o = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, load-use bubble,
// false-stall cases, flush priority and counter saturation (CNT_W=4).
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst_i;
  int   n_checks;
  int   n_fail;

  id_ex_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: present one ID instruction.
  task automatic drive_id(input logic rw, input logic m2r, input logic mr,
                          input logic mw, input logic asrc,
                          input logic [1:0] aop, input logic [9:0] fn,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] ard);
    bus.IDRegWrite_i = rw;
    bus.IDMemtoReg_i = m2r;
    bus.IDMemRead_i  = mr;
    bus.IDMemWrite_i = mw;
    bus.IDALUSrc_i   = asrc;
    bus.IDALUOp_i    = aop;
    bus.IDfunct_i    = fn;
    bus.IDRS1data_i  = d1;
    bus.IDRS2data_i  = d2;
    bus.IDImm_i      = imm;
    bus.IDRS1addr_i  = a1;
    bus.IDRS2addr_i  = a2;
    bus.IDRDaddr_i   = ard;
  endtask

  task automatic drive_random();
    drive_id(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             10'($urandom_range(0, 1023)), $urandom, $urandom, $urandom,
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)));
    bus.Flush_i = 1'($urandom_range(0, 1));
  endtask

  // Compare every registered EX field against expected values.
  task automatic check_ex(input string p, input logic rw, input logic m2r,
                          input logic mr, input logic mw, input logic asrc,
                          input logic [1:0] aop, input logic [9:0] fn,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] ard,
                          input logic vld);
    check({p, ".regwrite"}, 64'(bus.EXRegWrite_o), 64'(rw));
    check({p, ".memtoreg"}, 64'(bus.EXMemtoReg_o), 64'(m2r));
    check({p, ".memread"},  64'(bus.EXMemRead_o),  64'(mr));
    check({p, ".memwrite"}, 64'(bus.EXMemWrite_o), 64'(mw));
    check({p, ".alusrc"},   64'(bus.EXALUSrc_o),   64'(asrc));
    check({p, ".aluop"},    64'(bus.EXALUOp_o),    64'(aop));
    check({p, ".funct"},    64'(bus.EXfunct_o),    64'(fn));
    check({p, ".rs1data"},  64'(bus.EXRS1data_o),  64'(d1));
    check({p, ".rs2data"},  64'(bus.EXRS2data_o),  64'(d2));
    check({p, ".imm"},      64'(bus.EXImm_o),      64'(imm));
    check({p, ".rs1addr"},  64'(bus.EXRS1addr_o),  64'(a1));
    check({p, ".rs2addr"},  64'(bus.EXRS2addr_o),  64'(a2));
    check({p, ".rdaddr"},   64'(bus.EXRDaddr_o),   64'(ard));
    check({p, ".valid"},    64'(bus.EXValid_o),    64'(vld));
  endtask

  task automatic check_bubble(input string p);
    check_ex(p, 0, 0, 0, 0, 0, 2'd0, 10'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_random();
      tick();
    end
    drive_id(0, 0, 0, 0, 0, 2'd0, 10'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    bus.Flush_i = 1'b0;
    rst_i = 1'b1;
  endtask

  logic [CNT_W-1:0] exp_flush;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_i    = 1'b0;
    drive_id(0, 0, 0, 0, 0, 2'd0, 10'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    bus.Flush_i = 1'b0;
    #2;

    // Reset with random inputs: everything zero.
    rst_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_random();
      tick();
    end
    check_bubble("reset");
    check("reset.stallcnt", 64'(bus.StallCount_o), 64'd0);
    check("reset.flushcnt", 64'(bus.FlushCount_o), 64'd0);
    check("reset.stall",    64'(bus.Stall_o),      64'd0);
    drive_id(0, 0, 0, 0, 0, 2'd0, 10'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    bus.Flush_i = 1'b0;
    rst_i = 1'b1;

    // Pass-through: add x5, x3, x4.
    drive_id(1, 0, 0, 0, 0, 2'd2, 10'h000, 32'h11, 32'h22, 32'h0,
             5'd3, 5'd4, 5'd5);
    tick();
    check_ex("pass", 1, 0, 0, 0, 0, 2'd2, 10'h000, 32'h11, 32'h22, 32'h0,
             5'd3, 5'd4, 5'd5, 1);
    #1;
    check("pass.stall", 64'(bus.Stall_o), 64'd0);

    // Load-use via rs2: lw x7, 8(x1) then add x9, x2, x7.
    drive_id(1, 1, 1, 0, 1, 2'd0, 10'h002, 32'h40, 32'h0, 32'h8,
             5'd1, 5'd0, 5'd7);
    tick();
    check("lu.lw_memread", 64'(bus.EXMemRead_o), 64'd1);
    drive_id(1, 0, 0, 0, 0, 2'd2, 10'h000, 32'h5, 32'h6, 32'h0,
             5'd2, 5'd7, 5'd9);
    #1;
    check("lu.stall_same_cycle", 64'(bus.Stall_o), 64'd1);
    tick();
    check_bubble("lu.bubble");
    check("lu.stallcnt", 64'(bus.StallCount_o), 64'd1);
    check("lu.stall_after", 64'(bus.Stall_o), 64'd0);
    tick();
    check_ex("lu.dep", 1, 0, 0, 0, 0, 2'd2, 10'h000, 32'h5, 32'h6, 32'h0,
             5'd2, 5'd7, 5'd9, 1);
    check("lu.stallcnt_hold", 64'(bus.StallCount_o), 64'd1);

    // No false stall: load to x0 with ID reading x0.
    drive_id(0, 1, 1, 0, 1, 2'd0, 10'h002, 32'h0, 32'h0, 32'h4,
             5'd1, 5'd0, 5'd0);
    tick();
    drive_id(1, 0, 0, 0, 0, 2'd2, 10'h000, 32'h0, 32'h0, 32'h0,
             5'd0, 5'd3, 5'd8);
    #1;
    check("nofalse.rd0", 64'(bus.Stall_o), 64'd0);
    // No false stall: non-load writing x7 with ID reading x7.
    drive_id(1, 0, 0, 0, 0, 2'd2, 10'h000, 32'h1, 32'h2, 32'h0,
             5'd1, 5'd2, 5'd7);
    tick();
    drive_id(1, 0, 0, 0, 0, 2'd2, 10'h000, 32'h0, 32'h0, 32'h0,
             5'd7, 5'd3, 5'd8);
    #1;
    check("nofalse.notload", 64'(bus.Stall_o), 64'd0);
    check("nofalse.stallcnt", 64'(bus.StallCount_o), 64'd1);

    // Flush priority over a load-use (via rs1), from a fresh reset.
    do_reset();
    check("fp.reset_stallcnt", 64'(bus.StallCount_o), 64'd0);
    drive_id(1, 1, 1, 0, 1, 2'd0, 10'h002, 32'h40, 32'h0, 32'h8,
             5'd1, 5'd0, 5'd7);
    tick();
    drive_id(1, 0, 0, 0, 0, 2'd2, 10'h000, 32'h5, 32'h6, 32'h0,
             5'd7, 5'd2, 5'd9);
    bus.Flush_i = 1'b1;
    #1;
    check("fp.stall_rs1", 64'(bus.Stall_o), 64'd1);
    tick();
    bus.Flush_i = 1'b0;
    check_bubble("fp.bubble");
    check("fp.flushcnt", 64'(bus.FlushCount_o), 64'd1);
    check("fp.stallcnt", 64'(bus.StallCount_o), 64'd0);

    // Saturation: 20 back-to-back flushes on a 4-bit counter.
    exp_flush = 4'd1;
    bus.Flush_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_flush = (exp_flush == 4'd15) ? 4'd15 : exp_flush + 4'd1;
      check($sformatf("sat.flushcnt[%0d]", i), 64'(bus.FlushCount_o),
            64'(exp_flush));
    end
    bus.Flush_i = 1'b0;
    check("sat.final", 64'(bus.FlushCount_o), 64'd15);
    check("sat.stallcnt", 64'(bus.StallCount_o), 64'd0);
    check("sat.valid", 64'(bus.EXValid_o), 64'd0);

    // Reset mid-stall: lw in EX, dependent in ID, reset asserted.
    drive_id(1, 1, 1, 0, 1, 2'd0, 10'h002, 32'h40, 32'h0, 32'h8,
             5'd1, 5'd0, 5'd7);
    tick();
    drive_id(1, 0, 0, 0, 0, 2'd2, 10'h000, 32'h5, 32'h6, 32'h0,
             5'd7, 5'd7, 5'd9);
    #1;
    check("rst_mid.stall_before", 64'(bus.Stall_o), 64'd1);
    rst_i = 1'b0;
    tick();
    check("rst_mid.stall_after", 64'(bus.Stall_o), 64'd0);
    check("rst_mid.stallcnt", 64'(bus.StallCount_o), 64'd0);
    check("rst_mid.flushcnt", 64'(bus.FlushCount_o), 64'd0);
    rst_i = 1'b1;
    tick();
    check_ex("rst_mid.dep", 1, 0, 0, 0, 0, 2'd2, 10'h000, 32'h5, 32'h6,
             32'h0, 5'd7, 5'd7, 5'd9, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
